// File: rtl/npc_bht.sv
// Next-PC generator: direct-mapped BTB with 2-bit saturating direction counters,
// trained from EX-stage branch resolution; an EX redirect overrides any prediction.
module npc_bht #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_f,
  output logic [DATA_WIDTH-1:0] npc,
  output logic                  pred_taken,
  input  logic                  ex_br_valid,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic                  ex_taken,
  input  logic [DATA_WIDTH-1:0] ex_target,
  input  logic                  ex_redirect,
  input  logic [DATA_WIDTH-1:0] ex_redirect_pc,
  output logic [31:0]           br_cnt,
  output logic [31:0]           mispred_cnt
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned TAG_W   = DATA_WIDTH - IDX_BITS - 2;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  logic                  r_valid  [ENTRIES];
  logic [TAG_W-1:0]      r_tag    [ENTRIES];
  logic [DATA_WIDTH-1:0] r_target [ENTRIES];
  ctr_e                  r_ctr    [ENTRIES];
  logic [31:0]           r_br_cnt;
  logic [31:0]           r_mispred_cnt;

  logic [IDX_BITS-1:0]   w_f_idx;
  logic [TAG_W-1:0]      w_f_tag;
  logic                  w_f_hit;
  ctr_e                  w_f_ctr;
  logic                  w_f_pred;
  logic [DATA_WIDTH-1:0] w_pc_plus4;

  logic [IDX_BITS-1:0]   w_e_idx;
  logic [TAG_W-1:0]      w_e_tag;
  logic                  w_e_hit;
  ctr_e                  w_e_ctr;
  ctr_e                  w_e_ctr_next;
  logic                  w_e_alloc;

  // Fetch-side lookup
  assign w_f_idx    = pc_f[IDX_BITS+1:2];
  assign w_f_tag    = pc_f[DATA_WIDTH-1:IDX_BITS+2];
  assign w_f_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_f_ctr    = r_ctr[w_f_idx];
  assign w_f_pred   = w_f_hit && w_f_ctr[1];
  assign w_pc_plus4 = pc_f + DATA_WIDTH'(4);

  always_comb begin
    npc        = w_pc_plus4;
    pred_taken = 1'b0;
    if (ex_redirect) begin
      npc = ex_redirect_pc;
    end else if (w_f_pred) begin
      npc        = r_target[w_f_idx];
      pred_taken = 1'b1;
    end
  end

  // EX-side training lookup
  assign w_e_idx   = ex_pc[IDX_BITS+1:2];
  assign w_e_tag   = ex_pc[DATA_WIDTH-1:IDX_BITS+2];
  assign w_e_hit   = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
  assign w_e_ctr   = r_ctr[w_e_idx];
  assign w_e_alloc = ex_br_valid && !w_e_hit && ex_taken;

  always_comb begin
    w_e_ctr_next = w_e_ctr;
    if (ex_taken) begin
      case (w_e_ctr)
        CTR_SNT: w_e_ctr_next = CTR_WNT;
        CTR_WNT: w_e_ctr_next = CTR_WT;
        CTR_WT:  w_e_ctr_next = CTR_ST;
        default: w_e_ctr_next = CTR_ST;
      endcase
    end else begin
      case (w_e_ctr)
        CTR_ST:  w_e_ctr_next = CTR_WT;
        CTR_WT:  w_e_ctr_next = CTR_WNT;
        CTR_WNT: w_e_ctr_next = CTR_SNT;
        default: w_e_ctr_next = CTR_SNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_WNT;
      end
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (ex_br_valid && w_e_hit) begin
        r_ctr[w_e_idx] <= w_e_ctr_next;
      end else if (w_e_alloc) begin
        r_valid[w_e_idx] <= 1'b1;
        r_ctr[w_e_idx]   <= CTR_WT;
      end
      if (ex_br_valid && (r_br_cnt != '1)) begin
        r_br_cnt <= r_br_cnt + 32'd1;
      end
      if (ex_redirect && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

  // Tag/target need no reset: an entry is only consulted while its valid bit is set
  always_ff @(posedge clk) begin
    if (ex_br_valid && ex_taken) begin
      r_target[w_e_idx] <= ex_target;
      if (!w_e_hit) begin
        r_tag[w_e_idx] <= w_e_tag;
      end
    end
  end

  assign br_cnt      = r_br_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_npc_bht.sv
// Randomized scoreboard bench for npc_bht against a table-level reference model.
module tb_npc_bht;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_f = '0;
  logic [31:0] npc;
  logic        pred_taken;
  logic        ex_br_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_redirect_pc = '0;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  always #5 clk = ~clk;

  npc_bht #(.DATA_WIDTH(32), .IDX_BITS(4)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .npc(npc), .pred_taken(pred_taken),
    .ex_br_valid(ex_br_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_redirect(ex_redirect),
    .ex_redirect_pc(ex_redirect_pc), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic        chk;
    logic [31:0] npc;
    logic        pt;
    logic [31:0] br;
    logic [31:0] mis;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: 16 entries, plain integer direction strength 0..3
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_target[16];
  int          m_ctr   [16];
  logic [31:0] m_br, m_mis;

  function automatic int unsigned m_idx(input logic [31:0] pc);
    return (pc / 4) % 16;
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic step(input logic r, input logic [31:0] pc, input logic bv,
                      input logic [31:0] epc, input logic tk, input logic [31:0] tgt,
                      input logic rd, input logic [31:0] rpc, input string nm);
    exp_t e;
    int unsigned i;
    @(posedge clk);
    #1;
    rst = r; pc_f = pc; ex_br_valid = bv; ex_pc = epc; ex_taken = tk;
    ex_target = tgt; ex_redirect = rd; ex_redirect_pc = rpc;
    e.chk = !r; e.name = nm; e.br = m_br; e.mis = m_mis;
    if (rd) begin
      e.npc = rpc; e.pt = 1'b0;
    end else if (m_hit(pc) && m_ctr[m_idx(pc)] >= 2) begin
      e.npc = m_target[m_idx(pc)]; e.pt = 1'b1;
    end else begin
      e.npc = pc + 32'd4; e.pt = 1'b0;
    end
    q.push_back(e);
    if (r) begin
      m_reset();
    end else begin
      if (bv) begin
        i = m_idx(epc);
        if (m_hit(epc)) begin
          m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
          if (tk) m_target[i] = tgt;
        end else if (tk) begin
          m_valid[i] = 1; m_tag[i] = m_tagof(epc); m_target[i] = tgt; m_ctr[i] = 2;
        end
        if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      end
      if (rd && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
    end
  endtask

  task automatic idle(input logic [31:0] pc, input string nm);
    step(1'b0, pc, 1'b0, '0, 1'b0, '0, 1'b0, '0, nm);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] epc, input logic tk,
                       input logic [31:0] tgt, input string nm);
    step(1'b0, pc, 1'b1, epc, tk, tgt, 1'b0, '0, nm);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        n_checks++;
        if (npc !== e.npc) begin
          n_fail++;
          $display("FAIL %s npc: got %h expected %h", e.name, npc, e.npc);
        end
        n_checks++;
        if (pred_taken !== e.pt) begin
          n_fail++;
          $display("FAIL %s pred_taken: got %b expected %b", e.name, pred_taken, e.pt);
        end
        n_checks++;
        if (br_cnt !== e.br) begin
          n_fail++;
          $display("FAIL %s br_cnt: got %h expected %h", e.name, br_cnt, e.br);
        end
        n_checks++;
        if (mispred_cnt !== e.mis) begin
          n_fail++;
          $display("FAIL %s mispred_cnt: got %h expected %h", e.name, mispred_cnt, e.mis);
        end
      end
    end
  end

  function automatic logic [31:0] pool_pc();
    logic [31:0] p;
    if ($urandom_range(0, 15) == 0) return $urandom();
    p = 32'h0000_1000 + 32'($urandom_range(0, 31)) * 32'd4;
    if ($urandom_range(0, 1) == 1) p = p + 32'h0001_0000;
    return p | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int wait_cyc;
    m_reset();
    step(1'b1, 32'h100, 1'b0, '0, 1'b0, '0, 1'b0, '0, "rst");
    idle(32'h100, "reset_state");

    train(32'h100, 32'h200, 1'b1, 32'h80, "alloc");
    train(32'h200, 32'h200, 1'b0, 32'h0, "hit_wt_rbw");
    train(32'h200, 32'h200, 1'b0, 32'h0, "hit_wnt");
    train(32'h200, 32'h200, 1'b0, 32'h0, "snt_sat");
    idle(32'h200, "snt_hold");

    train(32'h100, 32'h300, 1'b1, 32'h500, "train300a");
    train(32'h100, 32'h300, 1'b1, 32'h500, "train300b");
    idle(32'h300, "hit300");
    step(1'b0, 32'h300, 1'b0, '0, 1'b0, '0, 1'b1, 32'h3000, "redirect");
    idle(32'h300, "after_redirect");

    train(32'h100, 32'h200, 1'b1, 32'h80, "alias_a");
    train(32'h100, 32'h240, 1'b1, 32'h90, "alias_b");
    idle(32'h200, "alias_200");
    idle(32'h240, "alias_240");
    idle(32'h243, "low_bits");

    step(1'b1, 32'h0, 1'b0, '0, 1'b0, '0, 1'b0, '0, "rst2");
    idle(32'hFFFF_FFFC, "wrap");
    idle(32'h240, "cleared");

    @(negedge clk);
    #1;
    force dut.r_mispred_cnt = 32'hFFFF_FFFF;
    force dut.r_br_cnt      = 32'hFFFF_FFFF;
    m_br  = 32'hFFFF_FFFF;
    m_mis = 32'hFFFF_FFFF;
    step(1'b0, 32'h100, 1'b1, 32'h400, 1'b1, 32'h40, 1'b1, 32'h3000, "sat_set");
    release dut.r_mispred_cnt;
    release dut.r_br_cnt;
    step(1'b0, 32'h100, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 32'h3004, "sat_hold");
    idle(32'h100, "sat_final");

    step(1'b1, 32'h0, 1'b0, '0, 1'b0, '0, 1'b0, '0, "rst3");
    for (int n = 0; n < 800; n++) begin
      logic r, bv, rd;
      r  = ($urandom_range(0, 199) == 0);
      bv = ($urandom_range(0, 2) != 0);
      rd = ($urandom_range(0, 7) == 0);
      step(r, pool_pc(), bv, pool_pc(), 1'($urandom_range(0, 1)), $urandom(), rd, $urandom(), "random");
    end
    idle(32'h100, "tail");

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
